// File: rtl/uart_mmio.sv
// CPU-facing register block that turns loads/stores into uart tx pushes and rx pops.
// Latency: bus_rdata/bus_rvalid, tx_en and rx_en all appear one cycle after the strobe.
// Backpressure: none; tx bursts are limited by software, early rx pops are silently dropped.
module uart_mmio #(
    parameter int RX_CAP = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  bus_addr,
    input  logic        bus_wen,
    input  logic        bus_ren,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_rvalid,
    output logic        irq,
    output logic        tx_en,
    output logic [7:0]  tx_data,
    output logic        rx_en,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready
);

    localparam logic [1:0] A_TX     = 2'd0;
    localparam logic [1:0] A_RX     = 2'd1;
    localparam logic [1:0] A_STATUS = 2'd2;
    localparam logic [1:0] A_CTRL   = 2'd3;
    localparam logic [7:0] RX_CAP_B = 8'(RX_CAP);

    logic        tx_en_q, tx_en_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [7:0]  tx_sent_q, tx_sent_d;
    logic [7:0]  rx_count_q, rx_count_d;
    logic        overflow_q, overflow_d;
    logic        irq_en_q, irq_en_d;
    logic        irq_q, irq_d;
    logic        rx_en_q, rx_en_d;
    logic [1:0]  pop_block_q, pop_block_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;

    logic        wr_tx, wr_ctrl, rd_ok, rx_avail, pop, ovf_evt;
    logic [31:0] status;

    logic unused_wdata;
    assign unused_wdata = ^bus_wdata[31:8];

    always_comb begin
        wr_tx    = bus_wen && (bus_addr == A_TX);
        wr_ctrl  = bus_wen && (bus_addr == A_CTRL);
        rd_ok    = bus_ren && !bus_wen;
        rx_avail = (rx_count_q != 8'd0);
        // The uart head byte is stale until one cycle after rx_en, hence pop_block.
        pop      = rd_ok && (bus_addr == A_RX) && rx_avail && (pop_block_q == 2'd0);
        ovf_evt  = rx_ready && !pop && (rx_count_q == RX_CAP_B);
        status   = {16'b0, rx_count_q, 5'b0, irq_en_q, overflow_q, rx_avail};

        tx_en_d   = wr_tx;
        tx_data_d = wr_tx ? bus_wdata[7:0] : tx_data_q;
        tx_sent_d = wr_tx ? tx_sent_q + 8'd1 : tx_sent_q;

        irq_en_d   = wr_ctrl ? bus_wdata[0] : irq_en_q;
        overflow_d = overflow_q;
        if (wr_ctrl && bus_wdata[1]) begin
            overflow_d = 1'b0;
        end
        if (ovf_evt) begin
            overflow_d = 1'b1;
        end

        rx_count_d = rx_count_q;
        if (rx_ready && !pop && !ovf_evt) begin
            rx_count_d = rx_count_q + 8'd1;
        end else if (pop && !rx_ready) begin
            rx_count_d = rx_count_q - 8'd1;
        end

        rx_en_d = pop;
        if (pop) begin
            pop_block_d = 2'd2;
        end else if (pop_block_q != 2'd0) begin
            pop_block_d = pop_block_q - 2'd1;
        end else begin
            pop_block_d = 2'd0;
        end

        irq_d    = irq_en_q && (rx_avail || overflow_q);
        rvalid_d = bus_ren;

        rdata_d = rdata_q;
        if (bus_ren) begin
            rdata_d = 32'd0;
            if (rd_ok) begin
                case (bus_addr)
                    A_TX:     rdata_d = {24'b0, tx_sent_q};
                    A_RX:     rdata_d = pop ? {24'b0, rx_data} : 32'd0;
                    A_STATUS: rdata_d = status;
                    A_CTRL:   rdata_d = {31'b0, irq_en_q};
                    default:  rdata_d = 32'd0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_en_q     <= 1'b0;
            tx_data_q   <= 8'd0;
            tx_sent_q   <= 8'd0;
            rx_count_q  <= 8'd0;
            overflow_q  <= 1'b0;
            irq_en_q    <= 1'b0;
            irq_q       <= 1'b0;
            rx_en_q     <= 1'b0;
            pop_block_q <= 2'd0;
            rdata_q     <= 32'd0;
            rvalid_q    <= 1'b0;
        end else begin
            tx_en_q     <= tx_en_d;
            tx_data_q   <= tx_data_d;
            tx_sent_q   <= tx_sent_d;
            rx_count_q  <= rx_count_d;
            overflow_q  <= overflow_d;
            irq_en_q    <= irq_en_d;
            irq_q       <= irq_d;
            rx_en_q     <= rx_en_d;
            pop_block_q <= pop_block_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
        end
    end

    assign tx_en      = tx_en_q;
    assign tx_data    = tx_data_q;
    assign rx_en      = rx_en_q;
    assign irq        = irq_q;
    assign bus_rdata  = rdata_q;
    assign bus_rvalid = rvalid_q;

endmodule

// File: tb/tb_uart_mmio.sv
// Bench for uart_mmio: directed scenarios plus random traffic against a cycle-level
// reference model with an emulated uart rx fifo.
module tb_uart_mmio;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  bus_addr = 2'd0;
    logic        bus_wen = 1'b0;
    logic        bus_ren = 1'b0;
    logic [31:0] bus_wdata = 32'd0;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;
    logic        irq;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        rx_en;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_ready = 1'b0;

    uart_mmio #(.RX_CAP(255)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus_addr   (bus_addr),
        .bus_wen    (bus_wen),
        .bus_ren    (bus_ren),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_rvalid (bus_rvalid),
        .irq        (irq),
        .tx_en      (tx_en),
        .tx_data    (tx_data),
        .rx_en      (rx_en),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference state, expressed directly in terms of the register rules.
    int          m_count;
    bit          m_ovf;
    bit          m_irq_en;
    int          m_sent;
    int          cyc;
    int          last_pop;
    logic [31:0] e_rdata;
    bit          e_rvalid, e_tx_en, e_rx_en, e_irq;
    logic [7:0]  e_tx_data;
    logic [7:0]  uq[$];
    bit          saw_rx_en;

    task automatic model_reset();
        m_count   = 0;
        m_ovf     = 0;
        m_irq_en  = 0;
        m_sent    = 0;
        last_pop  = cyc - 100;
        e_rdata   = 32'd0;
        e_rvalid  = 0;
        e_tx_en   = 0;
        e_rx_en   = 0;
        e_irq     = 0;
        e_tx_data = 8'd0;
        uq.delete();
        saw_rx_en = 0;
        rx_data   = 8'd0;
        bus_wen   = 1'b0;
        bus_ren   = 1'b0;
        bus_addr  = 2'd0;
        bus_wdata = 32'd0;
        rx_ready  = 1'b0;
    endtask

    // One clock cycle: drive, predict, advance, emulate uart, compare.
    task automatic cycle(input bit wen, input bit ren, input logic [1:0] addr,
                         input logic [31:0] wdata, input bit rdy, input logic [7:0] rbyte);
        bit          pop;
        bit          ovf_evt;
        logic [31:0] rv;
        bus_wen   = wen;
        bus_ren   = ren;
        bus_addr  = addr;
        bus_wdata = wdata;
        rx_ready  = rdy;

        e_irq = m_irq_en && (m_count > 0 || m_ovf);
        pop   = ren && !wen && addr == 2'd1 && m_count > 0 && (cyc - last_pop > 2);
        rv    = 32'd0;
        if (ren && !wen) begin
            case (addr)
                2'd0: rv = 32'(m_sent);
                2'd1: rv = pop ? {24'b0, rx_data} : 32'd0;
                2'd2: rv = {16'b0, 8'(m_count), 5'b0, m_irq_en, m_ovf, (m_count > 0)};
                default: rv = {31'b0, m_irq_en};
            endcase
        end
        e_rvalid = ren;
        if (ren) e_rdata = rv;
        e_tx_en = wen && addr == 2'd0;
        if (e_tx_en) begin
            e_tx_data = wdata[7:0];
            m_sent    = (m_sent + 1) % 256;
        end
        e_rx_en = pop;
        if (pop) last_pop = cyc;
        ovf_evt = 0;
        if (rdy && !pop) begin
            if (m_count == 255) ovf_evt = 1;
            else m_count++;
        end else if (pop && !rdy) begin
            m_count--;
        end
        if (wen && addr == 2'd3) begin
            m_irq_en = wdata[0];
            if (wdata[1]) m_ovf = 0;
        end
        if (ovf_evt) m_ovf = 1;

        @(posedge clk);
        #1;
        cyc++;
        if (saw_rx_en && uq.size() > 0) void'(uq.pop_front());
        if (rdy) uq.push_back(rbyte);
        saw_rx_en = rx_en;
        rx_data   = (uq.size() > 0) ? uq[0] : 8'h00;

        check("tx_en", 32'(tx_en), 32'(e_tx_en));
        if (e_tx_en) check("tx_data", 32'(tx_data), 32'(e_tx_data));
        check("rx_en", 32'(rx_en), 32'(e_rx_en));
        check("rvalid", 32'(bus_rvalid), 32'(e_rvalid));
        check("rdata", bus_rdata, e_rdata);
        check("irq", 32'(irq), 32'(e_irq));

        bus_wen  = 1'b0;
        bus_ren  = 1'b0;
        rx_ready = 1'b0;
    endtask

    task automatic idle();
        cycle(0, 0, 2'd0, 32'd0, 0, 8'd0);
    endtask
    task automatic rd(input logic [1:0] a);
        cycle(0, 1, a, 32'd0, 0, 8'd0);
    endtask
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cycle(1, 0, a, d, 0, 8'd0);
    endtask
    task automatic push(input logic [7:0] b);
        cycle(0, 0, 2'd0, 32'd0, 1, b);
    endtask

    task automatic hold_reset();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        hold_reset();
    endtask

    task automatic check_all_quiet(input string tag);
        check({tag, "_tx_en"}, 32'(tx_en), 32'd0);
        check({tag, "_rx_en"}, 32'(rx_en), 32'd0);
        check({tag, "_irq"}, 32'(irq), 32'd0);
        check({tag, "_rvalid"}, 32'(bus_rvalid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        cyc = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_quiet("reset");
        check("reset_rdata", bus_rdata, 32'd0);
        check("reset_tx_data", 32'(tx_data), 32'd0);
        rst_n = 1'b1;

        // Back-to-back tx writes and the write counter.
        wr(2'd0, 32'h41);
        check("tx1_data", 32'(tx_data), 32'h41);
        wr(2'd0, 32'h42);
        check("tx2_en", 32'(tx_en), 32'd1);
        check("tx2_data", 32'(tx_data), 32'h42);
        rd(2'd0);
        check("tx_sent", bus_rdata, 32'd2);

        // Single rx byte.
        push(8'h5A);
        idle();
        rd(2'd2);
        check("status_one", bus_rdata, 32'h0101);
        rd(2'd1);
        check("rx_byte", bus_rdata, 32'h5A);
        check("rx_rvalid", 32'(bus_rvalid), 32'd1);
        check("rx_pop", 32'(rx_en), 32'd1);
        idle();
        check("rx_pop_single", 32'(rx_en), 32'd0);
        rd(2'd2);
        check("status_empty", bus_rdata, 32'h0000);

        // Empty read, then an early second pop.
        rd(2'd1);
        check("empty_rdata", bus_rdata, 32'd0);
        check("empty_no_pop", 32'(rx_en), 32'd0);
        push(8'h11);
        push(8'h22);
        idle();
        rd(2'd1);
        check("first_of_two", bus_rdata, 32'h11);
        idle();
        rd(2'd1);
        check("early_rdata", bus_rdata, 32'd0);
        check("early_no_pop", 32'(rx_en), 32'd0);
        rd(2'd2);
        check("early_count", bus_rdata, 32'h0101);
        rd(2'd1);
        check("second_of_two", bus_rdata, 32'h22);

        // Pop coincident with rx_ready at count 3.
        push(8'h31);
        push(8'h32);
        push(8'h33);
        idle();
        cycle(0, 1, 2'd1, 32'd0, 1, 8'h34);
        check("simul_rdata", bus_rdata, 32'h31);
        rd(2'd2);
        check("simul_status", bus_rdata, 32'h0301);

        // Overflow at capacity.
        do_reset();
        repeat (255) push(8'($urandom));
        rd(2'd2);
        check("cap_status", bus_rdata, 32'hFF01);
        push(8'hAA);
        rd(2'd2);
        check("ovf_status", bus_rdata, 32'hFF03);
        wr(2'd3, 32'h2);
        rd(2'd2);
        check("ovf_clear", bus_rdata, 32'hFF01);
        cycle(1, 0, 2'd3, 32'h2, 1, 8'hBB);
        rd(2'd2);
        check("ovf_set_wins", bus_rdata, 32'hFF03);

        // Interrupt follows rx occupancy.
        do_reset();
        push(8'h77);
        wr(2'd3, 32'h1);
        idle();
        check("irq_on", 32'(irq), 32'd1);
        rd(2'd3);
        check("ctrl_read", bus_rdata, 32'd1);
        rd(2'd1);
        idle();
        idle();
        check("irq_off", 32'(irq), 32'd0);

        // Async reset cancels a pending tx push.
        wr(2'd0, 32'h55);
        check("pre_rst_tx", 32'(tx_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_quiet("rst_tx");
        hold_reset();

        // Async reset cancels a pending pop, read pulse and irq.
        wr(2'd3, 32'h1);
        push(8'h81);
        push(8'h82);
        idle();
        idle();
        rd(2'd1);
        check("pre_rst_rx", 32'(rx_en), 32'd1);
        check("pre_rst_irq", 32'(irq), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_quiet("rst_rx");
        hold_reset();
        rd(2'd2);
        check("post_rst_status", bus_rdata, 32'd0);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            bit          rdy;
            logic [31:0] wd;
            logic [1:0]  a;
            rdy = ($urandom_range(0, 5) == 0);
            wd  = $urandom;
            r   = $urandom_range(0, 99);
            a   = ($urandom_range(0, 1) == 0) ? 2'd1 : 2'($urandom_range(0, 3));
            if (r < 15)      cycle(1, 0, 2'd0, wd, rdy, 8'($urandom));
            else if (r < 20) cycle(1, 0, 2'd3, wd, rdy, 8'($urandom));
            else if (r < 50) cycle(0, 1, a, 32'd0, rdy, 8'($urandom));
            else if (r < 52) cycle(1, 1, a, wd, rdy, 8'($urandom));
            else             cycle(0, 0, 2'd0, 32'd0, rdy, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
